// File: rtl/regfile_pkg.sv
//==============================================================================
// Module : regfile_pkg
// Brief  : Shared types and constants for the parametrised register file.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package regfile_pkg;

   localparam int SEL_W      = 3;
   localparam int c_MAX_REGS = 8;

   localparam logic XFER_DIR_LOAD  = 1'b0;
   localparam logic XFER_DIR_STORE = 1'b1;

   typedef enum logic [1:0] {
      XFER_IDLE = 2'd0,
      XFER_LO   = 2'd1,
      XFER_HI   = 2'd2
   } xfer_state_e;

   function automatic logic sel_in_range(input logic [SEL_W-1:0] sel, input int n);
      return (32'(sel) < 32'(n));
   endfunction

endpackage

`default_nettype wire

// File: rtl/addrreg_param.sv
//==============================================================================
// Module : addrreg_param
// Brief  : AW-bit address register: byte write > load > inc/dec priority.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module addrreg_param #(
   parameter int DW = 8,
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we_lo,
   input  logic          i_we_hi,
   input  logic [DW-1:0] i_byte,
   input  logic          i_load,
   input  logic [AW-1:0] i_load_data,
   input  logic          i_inc,
   input  logic          i_dec,
   output logic [AW-1:0] o_q
);

   logic [AW-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_we_lo) begin
         r_q <= {r_q[AW-1:DW], i_byte};
      end else if (i_we_hi) begin
         r_q <= {i_byte, r_q[DW-1:0]};
      end else if (i_load) begin
         r_q <= i_load_data;
      end else if (i_inc && !i_dec) begin
         r_q <= r_q + AW'(1);
      end else if (i_dec && !i_inc) begin
         r_q <= r_q - AW'(1);
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/regfile_param.sv
//==============================================================================
// Module : regfile_param
// Brief  : GP + address register file with three read ports and a two-cycle
//          address<->main-bus byte-transfer sequencer.
// Config : REGFILE_WRITE_BYPASS_EN enables LHS/RHS read-during-write forwarding.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module regfile_param
   import regfile_pkg::*;
#(
   parameter int DW     = 8,
   parameter int AW     = 16,
   parameter int N_GP   = 8,
   parameter int N_ADDR = 4
) (
   input  logic             CLK,
   input  logic             RST_bar,
   input  logic             MAIN_LOAD_bar,
   input  logic [SEL_W-1:0] MAIN_LOAD_SEL,
   input  logic             MAIN_ASSERT_bar,
   input  logic             LHS_ASSERT_bar,
   input  logic             RHS_ASSERT_bar,
   input  logic [SEL_W-1:0] MAIN_ASSERT_SEL,
   input  logic [SEL_W-1:0] LHS_ASSERT_SEL,
   input  logic [SEL_W-1:0] RHS_ASSERT_SEL,
   input  logic [DW-1:0]    MAIN_in,
   output logic [DW-1:0]    MAIN_out,
   output logic [DW-1:0]    LHS_out,
   output logic [DW-1:0]    RHS_out,
   input  logic             ADDR_LOAD_bar,
   input  logic [SEL_W-1:0] ADDR_LOAD_SEL,
   input  logic             ADDR_INC,
   input  logic             ADDR_DEC,
   input  logic [SEL_W-1:0] ADDR_INC_SEL,
   input  logic             ADDR_ASSERT_bar,
   input  logic [SEL_W-1:0] ADDR_ASSERT_SEL,
   input  logic [AW-1:0]    ADDR_in,
   output logic [AW-1:0]    ADDR_out,
   input  logic             XFER_START,
   input  logic             XFER_DIR,
   input  logic [SEL_W-1:0] XFER_SEL,
   output logic             XFER_BUSY,
   output logic             XFER_DONE
);

   generate
      if (AW != 2 * DW) begin : g_chk_aw
         $error("regfile_param: AW must equal 2*DW");
      end
      if (N_GP < 1 || N_GP > c_MAX_REGS) begin : g_chk_gp
         $error("regfile_param: N_GP must be 1..8");
      end
      if (N_ADDR < 1 || N_ADDR > c_MAX_REGS) begin : g_chk_addr
         $error("regfile_param: N_ADDR must be 1..8");
      end
   endgenerate

   // Arrays are padded to the full select range; absent entries read as zero.
   logic [DW-1:0]    w_gp [c_MAX_REGS];
   logic [AW-1:0]    w_a  [c_MAX_REGS];

   xfer_state_e      r_state, w_state_nxt;
   logic             r_dir,   w_dir_nxt;
   logic [SEL_W-1:0] r_sel,   w_sel_nxt;
   logic             r_done,  w_done_nxt;

   generate
      for (genvar gi = 0; gi < c_MAX_REGS; gi++) begin : g_gp
         if (gi < N_GP) begin : g_reg
            logic [DW-1:0] r_val;
            always_ff @(posedge CLK or negedge RST_bar) begin
               if (!RST_bar) begin
                  r_val <= '0;
               end else if (!MAIN_LOAD_bar && (MAIN_LOAD_SEL == SEL_W'(gi))) begin
                  r_val <= MAIN_in;
               end
            end
            assign w_gp[gi] = r_val;
         end else begin : g_pad
            assign w_gp[gi] = '0;
         end
      end

      for (genvar ai = 0; ai < c_MAX_REGS; ai++) begin : g_addr
         if (ai < N_ADDR) begin : g_reg
            logic w_xfer_hit;
            assign w_xfer_hit = (r_sel == SEL_W'(ai)) && (r_dir == XFER_DIR_LOAD);
            addrreg_param #(
               .DW (DW),
               .AW (AW)
            ) u_areg (
               .clk         (CLK),
               .rst_n       (RST_bar),
               .i_we_lo     (w_xfer_hit && (r_state == XFER_LO)),
               .i_we_hi     (w_xfer_hit && (r_state == XFER_HI)),
               .i_byte      (MAIN_in),
               .i_load      (!ADDR_LOAD_bar && (ADDR_LOAD_SEL == SEL_W'(ai))),
               .i_load_data (ADDR_in),
               .i_inc       (ADDR_INC && (ADDR_INC_SEL == SEL_W'(ai))),
               .i_dec       (ADDR_DEC && (ADDR_INC_SEL == SEL_W'(ai))),
               .o_q         (w_a[ai])
            );
         end else begin : g_pad
            assign w_a[ai] = '0;
         end
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST_bar) begin
      if (!RST_bar) begin
         r_state <= XFER_IDLE;
         r_dir   <= XFER_DIR_LOAD;
         r_sel   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dir   <= w_dir_nxt;
         r_sel   <= w_sel_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_sel_nxt   = r_sel;
      w_done_nxt  = 1'b0;
      case (r_state)
         XFER_IDLE: begin
            if (XFER_START && sel_in_range(XFER_SEL, N_ADDR)) begin
               w_state_nxt = XFER_LO;
               w_dir_nxt   = XFER_DIR;
               w_sel_nxt   = XFER_SEL;
            end
         end
         XFER_LO: w_state_nxt = XFER_HI;
         XFER_HI: begin
            w_state_nxt = XFER_IDLE;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = XFER_IDLE;
      endcase
   end

   assign XFER_BUSY = (r_state != XFER_IDLE);
   assign XFER_DONE = r_done;

   logic          w_store;
   logic [DW-1:0] w_xfer_byte;
   logic [AW-1:0] w_xfer_reg;

   assign w_store     = (r_dir == XFER_DIR_STORE) && (r_state != XFER_IDLE);
   assign w_xfer_reg  = w_a[r_sel];
   assign w_xfer_byte = (r_state == XFER_LO) ? w_xfer_reg[DW-1:0] : w_xfer_reg[AW-1:DW];

   // Everything reads zero while reset is held, including forwarded data.
   always_comb begin
      MAIN_out = '0;
      LHS_out  = '0;
      RHS_out  = '0;
      ADDR_out = '0;
      if (RST_bar) begin
         if (w_store) begin
            MAIN_out = w_xfer_byte;
         end else if (!MAIN_ASSERT_bar && sel_in_range(MAIN_ASSERT_SEL, N_GP)) begin
            MAIN_out = w_gp[MAIN_ASSERT_SEL];
         end
         if (!LHS_ASSERT_bar && sel_in_range(LHS_ASSERT_SEL, N_GP)) begin
            LHS_out = w_gp[LHS_ASSERT_SEL];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (!MAIN_LOAD_bar && (MAIN_LOAD_SEL == LHS_ASSERT_SEL)) begin
               LHS_out = MAIN_in;
            end
`endif
         end
         if (!RHS_ASSERT_bar && sel_in_range(RHS_ASSERT_SEL, N_GP)) begin
            RHS_out = w_gp[RHS_ASSERT_SEL];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (!MAIN_LOAD_bar && (MAIN_LOAD_SEL == RHS_ASSERT_SEL)) begin
               RHS_out = MAIN_in;
            end
`endif
         end
         if (!ADDR_ASSERT_bar && sel_in_range(ADDR_ASSERT_SEL, N_ADDR)) begin
            ADDR_out = w_a[ADDR_ASSERT_SEL];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
//==============================================================================
// Module : tb_regfile_param
// Brief  : Directed scoreboard bench for regfile_param.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_regfile_param;

   localparam int P_MAIN = 0;
   localparam int P_LHS  = 1;
   localparam int P_RHS  = 2;
   localparam int P_ADDR = 3;
   localparam int P_BUSY = 4;
   localparam int P_DONE = 5;

   logic        CLK;
   logic        RST_bar;
   logic        MAIN_LOAD_bar;
   logic [2:0]  MAIN_LOAD_SEL;
   logic        MAIN_ASSERT_bar, LHS_ASSERT_bar, RHS_ASSERT_bar;
   logic [2:0]  MAIN_ASSERT_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL;
   logic [7:0]  MAIN_in;
   logic [7:0]  MAIN_out, LHS_out, RHS_out;
   logic        ADDR_LOAD_bar;
   logic [2:0]  ADDR_LOAD_SEL;
   logic        ADDR_INC, ADDR_DEC;
   logic [2:0]  ADDR_INC_SEL;
   logic        ADDR_ASSERT_bar;
   logic [2:0]  ADDR_ASSERT_SEL;
   logic [15:0] ADDR_in;
   logic [15:0] ADDR_out;
   logic        XFER_START, XFER_DIR;
   logic [2:0]  XFER_SEL;
   logic        XFER_BUSY, XFER_DONE;

   regfile_param #(.DW(8), .AW(16), .N_GP(8), .N_ADDR(4)) dut (
      .CLK             (CLK),
      .RST_bar         (RST_bar),
      .MAIN_LOAD_bar   (MAIN_LOAD_bar),
      .MAIN_LOAD_SEL   (MAIN_LOAD_SEL),
      .MAIN_ASSERT_bar (MAIN_ASSERT_bar),
      .LHS_ASSERT_bar  (LHS_ASSERT_bar),
      .RHS_ASSERT_bar  (RHS_ASSERT_bar),
      .MAIN_ASSERT_SEL (MAIN_ASSERT_SEL),
      .LHS_ASSERT_SEL  (LHS_ASSERT_SEL),
      .RHS_ASSERT_SEL  (RHS_ASSERT_SEL),
      .MAIN_in         (MAIN_in),
      .MAIN_out        (MAIN_out),
      .LHS_out         (LHS_out),
      .RHS_out         (RHS_out),
      .ADDR_LOAD_bar   (ADDR_LOAD_bar),
      .ADDR_LOAD_SEL   (ADDR_LOAD_SEL),
      .ADDR_INC        (ADDR_INC),
      .ADDR_DEC        (ADDR_DEC),
      .ADDR_INC_SEL    (ADDR_INC_SEL),
      .ADDR_ASSERT_bar (ADDR_ASSERT_bar),
      .ADDR_ASSERT_SEL (ADDR_ASSERT_SEL),
      .ADDR_in         (ADDR_in),
      .ADDR_out        (ADDR_out),
      .XFER_START      (XFER_START),
      .XFER_DIR        (XFER_DIR),
      .XFER_SEL        (XFER_SEL),
      .XFER_BUSY       (XFER_BUSY),
      .XFER_DONE       (XFER_DONE)
   );

   typedef struct {
      int          cyc;
      int          port;
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic end_req = 1'b0;
   logic [15:0] mon_act;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] port_val(input int p);
      case (p)
         P_MAIN:  return {8'h00, MAIN_out};
         P_LHS:   return {8'h00, LHS_out};
         P_RHS:   return {8'h00, RHS_out};
         P_ADDR:  return ADDR_out;
         P_BUSY:  return {15'd0, XFER_BUSY};
         default: return {15'd0, XFER_DONE};
      endcase
   endfunction

   task automatic exp_out(input int port, input logic [15:0] val, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.port = port;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: samples 2 time units after the falling edge, well clear of the rising edge.
   initial begin
      forever begin
         @(negedge CLK);
         #2;
         while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = port_val(mon_e.port);
            n_tests++;
            if (mon_act !== mon_e.val) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.val);
            end
         end
         if (end_req) begin
            if (sb.size() != 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
            end
            break;
         end
      end
   end

   task automatic clear_inputs();
      MAIN_LOAD_bar   = 1'b1;  MAIN_LOAD_SEL   = 3'd0;
      MAIN_ASSERT_bar = 1'b1;  MAIN_ASSERT_SEL = 3'd0;
      LHS_ASSERT_bar  = 1'b1;  LHS_ASSERT_SEL  = 3'd0;
      RHS_ASSERT_bar  = 1'b1;  RHS_ASSERT_SEL  = 3'd0;
      MAIN_in         = 8'h00;
      ADDR_LOAD_bar   = 1'b1;  ADDR_LOAD_SEL   = 3'd0;
      ADDR_INC        = 1'b0;  ADDR_DEC        = 1'b0;  ADDR_INC_SEL = 3'd0;
      ADDR_ASSERT_bar = 1'b1;  ADDR_ASSERT_SEL = 3'd0;
      ADDR_in         = 16'h0000;
      XFER_START      = 1'b0;  XFER_DIR = 1'b0;  XFER_SEL = 3'd0;
   endtask

   task automatic tick();
      @(negedge CLK);
      clear_inputs();
   endtask

   task automatic rd_addr(input logic [2:0] sel, input logic [15:0] v, input string name);
      ADDR_ASSERT_bar = 1'b0;
      ADDR_ASSERT_SEL = sel;
      exp_out(P_ADDR, v, name);
   endtask

   initial begin
      RST_bar = 1'b0;
      clear_inputs();
      tick();
      tick();
      MAIN_ASSERT_bar = 1'b0; LHS_ASSERT_bar = 1'b0; RHS_ASSERT_bar = 1'b0;
      rd_addr(3'd0, 16'h0000, "rst_addr");
      exp_out(P_MAIN, 16'h0000, "rst_main");
      exp_out(P_LHS,  16'h0000, "rst_lhs");
      exp_out(P_BUSY, 16'h0000, "rst_busy");
      exp_out(P_DONE, 16'h0000, "rst_done");
      tick();
      RST_bar = 1'b1;

      // General registers
      MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd3; MAIN_in = 8'hA5;
      tick();
      MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd5; MAIN_in = 8'h3C;
      tick();
      LHS_ASSERT_bar = 1'b0; LHS_ASSERT_SEL = 3'd3;
      RHS_ASSERT_bar = 1'b0; RHS_ASSERT_SEL = 3'd5;
      MAIN_ASSERT_SEL = 3'd3;
      exp_out(P_LHS,  16'h00A5, "lhs_gp3");
      exp_out(P_RHS,  16'h003C, "rhs_gp5");
      exp_out(P_MAIN, 16'h0000, "main_deasserted");
      tick();
      LHS_ASSERT_SEL = 3'd3;
      MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = 3'd3;
      exp_out(P_LHS,  16'h0000, "lhs_deasserted");
      exp_out(P_MAIN, 16'h00A5, "main_gp3");

      // Address registers
      tick();
      ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd1; ADDR_in = 16'hFFFF;
      tick();
      rd_addr(3'd1, 16'hFFFF, "a1_load");
      ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd1;
      tick();
      rd_addr(3'd1, 16'h0000, "a1_inc_wrap");
      ADDR_DEC = 1'b1; ADDR_INC_SEL = 3'd1;
      tick();
      rd_addr(3'd1, 16'hFFFF, "a1_dec_wrap");
      ADDR_INC = 1'b1; ADDR_DEC = 1'b1; ADDR_INC_SEL = 3'd1;
      tick();
      rd_addr(3'd1, 16'hFFFF, "a1_incdec_hold");
      ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd2; ADDR_in = 16'h5555;
      ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd1;
      tick();
      rd_addr(3'd1, 16'h0000, "a1_inc_concurrent");
      tick();
      rd_addr(3'd2, 16'h5555, "a2_load_concurrent");
      tick();
      rd_addr(3'd5, 16'h0000, "addr_sel_oor");

      // Load transfer into A2
      tick();
      XFER_START = 1'b1; XFER_DIR = 1'b0; XFER_SEL = 3'd2;
      tick();
      exp_out(P_BUSY, 16'h0001, "xfer_busy_lo");
      exp_out(P_DONE, 16'h0000, "xfer_done_lo");
      MAIN_in = 8'h34;
      tick();
      exp_out(P_BUSY, 16'h0001, "xfer_busy_hi");
      MAIN_in = 8'h12;
      XFER_START = 1'b1; XFER_DIR = 1'b1; XFER_SEL = 3'd3;
      tick();
      exp_out(P_BUSY, 16'h0000, "xfer_busy_end");
      exp_out(P_DONE, 16'h0001, "xfer_done_pulse");
      rd_addr(3'd2, 16'h1234, "a2_xfer_load");
      tick();
      exp_out(P_DONE, 16'h0000, "xfer_done_once");
      exp_out(P_BUSY, 16'h0000, "xfer_busy_start_ignored");

      // Store transfer from A0, then a back-to-back start from A3
      ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd0; ADDR_in = 16'hBEEF;
      MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd1; MAIN_in = 8'h5A;
      tick();
      XFER_START = 1'b1; XFER_DIR = 1'b1; XFER_SEL = 3'd0;
      MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = 3'd1;
      exp_out(P_MAIN, 16'h005A, "main_gp1_idle");
      tick();
      MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = 3'd1;
      exp_out(P_MAIN, 16'h00EF, "xfer_store_lo");
      tick();
      MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = 3'd1;
      exp_out(P_MAIN, 16'h00BE, "xfer_store_hi");
      tick();
      MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = 3'd1;
      exp_out(P_MAIN, 16'h005A, "main_gp1_after");
      exp_out(P_DONE, 16'h0001, "store_done");
      XFER_START = 1'b1; XFER_DIR = 1'b1; XFER_SEL = 3'd3;
      tick();
      MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = 3'd1;
      exp_out(P_BUSY, 16'h0001, "b2b_accept");
      exp_out(P_MAIN, 16'h0000, "b2b_lo");
      tick();
      tick();
      exp_out(P_DONE, 16'h0001, "b2b_done");

      // Out-of-range start
      tick();
      XFER_START = 1'b1; XFER_SEL = 3'd5;
      tick();
      exp_out(P_BUSY, 16'h0000, "start_oor_ignored");

      // Reset in the middle of a load transfer
      tick();
      XFER_START = 1'b1; XFER_DIR = 1'b0; XFER_SEL = 3'd1;
      tick();
      RST_bar = 1'b0;
      MAIN_in = 8'h99;
      exp_out(P_BUSY, 16'h0000, "rst_busy_drop");
      tick();
      RST_bar = 1'b1;
      exp_out(P_DONE, 16'h0000, "rst_no_done");
      LHS_ASSERT_bar = 1'b0; LHS_ASSERT_SEL = 3'd3;
      exp_out(P_LHS, 16'h0000, "rst_gp3_cleared");
      rd_addr(3'd0, 16'h0000, "rst_a0_cleared");
      tick();
      exp_out(P_DONE, 16'h0000, "rst_no_done_late");
      exp_out(P_BUSY, 16'h0000, "rst_idle");
      rd_addr(3'd2, 16'h0000, "rst_a2_cleared");

      // Read during write
      tick();
      MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd4; MAIN_in = 8'h11;
      tick();
      MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd4; MAIN_in = 8'h77;
      RHS_ASSERT_bar = 1'b0; RHS_ASSERT_SEL = 3'd4;
      MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = 3'd4;
`ifdef REGFILE_WRITE_BYPASS_EN
      exp_out(P_RHS, 16'h0077, "rhs_bypass");
`else
      exp_out(P_RHS, 16'h0011, "rhs_old_value");
`endif
      exp_out(P_MAIN, 16'h0011, "main_no_bypass");
      tick();
      RHS_ASSERT_bar = 1'b0; RHS_ASSERT_SEL = 3'd4;
      exp_out(P_RHS, 16'h0077, "rhs_after_write");

      tick();
      end_req = 1'b1;
      repeat (3) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
